iter_divider_ctrl: RTL and testbench

- Multi-cycle integer divider controller for the Frost32 ALU path.
- Sequences a shared DATA_WIDTH-bit subtractor and 1-bit left shift, one quotient bit per cycle, with sign pre- and post-processing.
- Uses valid/ready handshakes on both sides and sits beside the single-cycle ALU in the execute stage.
- Execute stage stalls while the divider is busy and flushes it with in_abort.

---
 rtl/iter_divider_ctrl.sv | 166 ++++++++++++++++
 tb/tb_iter_divider_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/iter_divider_ctrl.sv
// ============================================================================
// iter_divider_ctrl : restoring integer divider, one quotient bit per cycle,
//                     signed/unsigned, valid/ready handshakes and abort flush.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iter_divider_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_signed,
  input  logic                  in_abort,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quot,
  output logic [DATA_WIDTH-1:0] out_rem,
  output logic                  out_div_by_zero,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_CNT_LOAD = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] C_CNT_ONE  = CNT_WIDTH'(1);

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_rem, w_rem_nxt;
  logic [DATA_WIDTH-1:0] r_quot, w_quot_nxt;
  logic [DATA_WIDTH-1:0] r_div, w_div_nxt;
  logic                  r_neg_q, w_neg_q_nxt;
  logic                  r_neg_r, w_neg_r_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_out_quot_nxt, w_out_rem_nxt;
  logic                  w_out_dbz_nxt;

  logic                  w_accept;
  logic                  w_a_neg, w_b_neg;
  logic [DATA_WIDTH-1:0] w_a_mag, w_b_mag;
  logic [DATA_WIDTH:0]   w_rem_sh;
  logic [DATA_WIDTH:0]   w_trial;
  logic                  w_borrow;

  assign in_ready  = (r_state == S_IDLE) && !in_abort;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ITER) || (r_state == S_FIXUP);
  assign w_accept  = in_valid && in_ready;

  assign w_a_neg = in_signed & in_a[DATA_WIDTH-1];
  assign w_b_neg = in_signed & in_b[DATA_WIDTH-1];
  assign w_a_mag = w_a_neg ? ({DATA_WIDTH{1'b0}} - in_a) : in_a;
  assign w_b_mag = w_b_neg ? ({DATA_WIDTH{1'b0}} - in_b) : in_b;

  // The shifted remainder can exceed DATA_WIDTH bits; when its top bit is set
  // the subtraction can never borrow, otherwise bit DATA_WIDTH of the
  // difference is the borrow.
  assign w_rem_sh = {r_rem, r_quot[DATA_WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_div};
  assign w_borrow = ~w_rem_sh[DATA_WIDTH] & w_trial[DATA_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rem_nxt      = r_rem;
    w_quot_nxt     = r_quot;
    w_div_nxt      = r_div;
    w_neg_q_nxt    = r_neg_q;
    w_neg_r_nxt    = r_neg_r;
    w_cnt_nxt      = r_cnt;
    w_out_quot_nxt = out_quot;
    w_out_rem_nxt  = out_rem;
    w_out_dbz_nxt  = out_div_by_zero;

    if (in_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_neg_q_nxt = w_a_neg ^ w_b_neg;
            w_neg_r_nxt = w_a_neg;
            w_div_nxt   = w_b_mag;
            if (in_b == '0) begin
              w_out_quot_nxt = '1;
              w_out_rem_nxt  = in_a;
              w_out_dbz_nxt  = 1'b1;
              w_state_nxt    = S_DONE;
            end else begin
              w_rem_nxt   = '0;
              w_quot_nxt  = w_a_mag;
              w_cnt_nxt   = C_CNT_LOAD;
              w_state_nxt = S_ITER;
            end
          end
        end
        S_ITER: begin
          w_quot_nxt = {r_quot[DATA_WIDTH-2:0], ~w_borrow};
          w_rem_nxt  = w_borrow ? w_rem_sh[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
          w_cnt_nxt  = r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) begin
            w_state_nxt = S_FIXUP;
          end
        end
        S_FIXUP: begin
          w_out_quot_nxt = r_neg_q ? ({DATA_WIDTH{1'b0}} - r_quot) : r_quot;
          w_out_rem_nxt  = r_neg_r ? ({DATA_WIDTH{1'b0}} - r_rem) : r_rem;
          w_out_dbz_nxt  = 1'b0;
          w_state_nxt    = S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem           <= '0;
      r_quot          <= '0;
      r_div           <= '0;
      r_neg_q         <= 1'b0;
      r_neg_r         <= 1'b0;
      r_cnt           <= '0;
      out_quot        <= '0;
      out_rem         <= '0;
      out_div_by_zero <= 1'b0;
    end else begin
      r_rem           <= w_rem_nxt;
      r_quot          <= w_quot_nxt;
      r_div           <= w_div_nxt;
      r_neg_q         <= w_neg_q_nxt;
      r_neg_r         <= w_neg_r_nxt;
      r_cnt           <= w_cnt_nxt;
      out_quot        <= w_out_quot_nxt;
      out_rem         <= w_out_rem_nxt;
      out_div_by_zero <= w_out_dbz_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iter_divider_ctrl.sv
// ============================================================================
// tb_iter_divider_ctrl : directed self-checking bench for iter_divider_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iter_divider_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_signed = 1'b0;
  logic         in_abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_ready, out_valid, out_div_by_zero, busy;
  logic [W-1:0] out_quot, out_rem;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  iter_divider_ctrl #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_abort(in_abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quot(out_quot), .out_rem(out_rem),
    .out_div_by_zero(out_div_by_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid, and busy samples.
  task automatic wait_result(output int n, output int bcnt);
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dbz, input int lat);
    int n, bcnt;
    launch(a, b, s);
    wait_result(n, bcnt);
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".busy_cycles"}, bcnt, (lat == 0) ? 0 : lat);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".quot"}, out_quot, q);
    chk({tag, ".rem"}, out_rem, r);
    chk({tag, ".dbz"}, out_div_by_zero, dbz);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".ready_back"}, in_ready, 1);
  endtask

  initial begin
    int n, bcnt, seen;

    #2;
    chk("rst.valid", out_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.quot", out_quot, 0);
    chk("rst.rem", out_rem, 0);
    chk("rst.dbz", out_div_by_zero, 0);
    #10 rst_n = 1'b1;
    tick();

    run_div("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33);
    run_div("s-7_2",    32'hFFFF_FFF9,  32'h2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33);
    run_div("s7_-2",    32'h7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'h1,          1'b0, 33);
    run_div("uFFF9_2",  32'hFFFF_FFF9,  32'h2,          1'b0, 32'h7FFF_FFFC,  32'h1,          1'b0, 33);
    run_div("u_dbz",    32'h1234,       32'h0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1, 0);
    run_div("s_dbz",    32'h1234,       32'h0,          1'b1, 32'hFFFF_FFFF,  32'h1234,       1'b1, 0);
    run_div("s_min_-1", 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'h0,          1'b0, 33);

    // Backpressure: result held while a competing request is presented.
    launch(32'd200, 32'd9, 1'b0);
    wait_result(n, bcnt);
    chk("bp.latency", n, 33);
    in_a = 32'd77; in_b = 32'd7; in_signed = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.hold_valid", out_valid, 1);
      chk("bp.hold_quot", out_quot, 32'd22);
      chk("bp.hold_rem", out_rem, 32'd2);
      chk("bp.in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.idle_valid", out_valid, 0);
    chk("bp.idle_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("b2b.busy", busy, 1);
    wait_result(n, bcnt);
    chk("b2b.latency", n, 33);
    chk("b2b.quot", out_quot, 32'd11);
    chk("b2b.rem", out_rem, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Abort during iteration 10.
    launch(32'd1000, 32'd3, 1'b0);
    repeat (9) tick();
    chk("abort.busy_before", busy, 1);
    in_abort = 1'b1;
    tick();
    in_abort = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.valid", out_valid, 0);
    chk("abort.in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    chk("abort.no_result", seen, 0);
    in_abort = 1'b1;
    #1;
    chk("abort.blocks_ready", in_ready, 0);
    in_a = 32'd5; in_b = 32'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_abort = 1'b0;
    chk("abort.not_accepted", busy, 0);
    run_div("u50_5", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 33);

    // Asynchronous reset mid-iteration, between clock edges.
    launch(32'd1234, 32'd7, 1'b0);
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    chk("areset.valid", out_valid, 0);
    chk("areset.busy", busy, 0);
    chk("areset.in_ready", in_ready, 1);
    chk("areset.quot", out_quot, 0);
    #2 rst_n = 1'b1;
    tick();
    run_div("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
